// File: rtl/pipe_pkg.sv
// Shared widths and the packed decode->execute bundle used by the DE pipeline register.
package pipe_pkg;

   localparam int ALUC_W   = 4;
   localparam int RN_W     = 5;
   localparam int DATA_W   = 32;
   localparam int BUNDLE_W = 6 + ALUC_W + 4 * DATA_W + RN_W;

   typedef struct packed {
      logic              wreg;
      logic              m2reg;
      logic              wmem;
      logic              aluimm;
      logic              shift;
      logic              jal;
      logic [ALUC_W-1:0] aluc;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc4;
      logic [RN_W-1:0]   rn;
   } bundle_t;

endpackage

// File: rtl/pipe_de_skid_if.sv
// Decode/execute handshake bus: the decode side offers a bundle and the execute side drains it.
interface pipe_de_skid_if;
   import pipe_pkg::*;

   logic              dvalid;
   logic              dready;
   logic              dwreg, dm2reg, dwmem, daluimm, dshift, djal;
   logic [ALUC_W-1:0] daluc;
   logic [DATA_W-1:0] da, db, dimm, dpc4;
   logic [RN_W-1:0]   drn;

   logic              evalid;
   logic              eready;
   logic              ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
   logic [ALUC_W-1:0] ealuc;
   logic [DATA_W-1:0] ea, eb, eimm, epc4;
   logic [RN_W-1:0]   ern0;

   logic              flush;

   modport master (
      output dvalid, dwreg, dm2reg, dwmem, daluimm, dshift, djal, daluc, da, db, dimm, dpc4, drn,
      output eready, flush,
      input  dready,
      input  evalid, ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ea, eb, eimm, epc4, ern0
   );

   modport slave (
      input  dvalid, dwreg, dm2reg, dwmem, daluimm, dshift, djal, daluc, da, db, dimm, dpc4, drn,
      input  eready, flush,
      output dready,
      output evalid, ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ea, eb, eimm, epc4, ern0
   );

endinterface

// File: rtl/pipe_de_slot.sv
// One pipeline slot: a valid flag plus a bundle register; clear wins over load.
module pipe_de_slot #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout
);

   // Clearing only drops the valid flag; the stale payload is masked downstream.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end
   end

endmodule

// File: rtl/pipe_de_skid.sv
// Decode->execute pipeline register with a skid slot so dready is purely registered.
// Optional PIPE_DE_PERF_EN adds a saturating stall_cnt output.
module pipe_de_skid
   import pipe_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   pipe_de_skid_if.slave bus
`ifdef PIPE_DE_PERF_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   bundle_t inBundle;
   bundle_t outDin;
   bundle_t outData;
   bundle_t skidData;
   logic    outValid, skidValid;
   logic    outLoad, outClear, skidLoad, skidClear;
   logic    accept;

   assign inBundle = '{wreg: bus.dwreg, m2reg: bus.dm2reg, wmem: bus.dwmem,
                       aluimm: bus.daluimm, shift: bus.dshift, jal: bus.djal,
                       aluc: bus.daluc, a: bus.da, b: bus.db, imm: bus.dimm,
                       pc4: bus.dpc4, rn: bus.drn};

   assign bus.dready = ~skidValid;
   assign accept     = bus.dvalid & ~skidValid;

   // The skid slot only fills while the output slot is stalled, and always drains first.
   always_comb begin
      outLoad   = 1'b0;
      outClear  = 1'b0;
      skidLoad  = 1'b0;
      skidClear = 1'b0;
      outDin    = inBundle;
      if (bus.flush) begin
         outClear  = 1'b1;
         skidClear = 1'b1;
      end else if (!outValid || bus.eready) begin
         if (skidValid) begin
            outLoad   = 1'b1;
            outDin    = skidData;
            skidClear = 1'b1;
         end else if (accept) begin
            outLoad = 1'b1;
         end else begin
            outClear = 1'b1;
         end
      end else if (accept) begin
         skidLoad = 1'b1;
      end
   end

   pipe_de_slot #(.W(BUNDLE_W)) outSlot (
      .clock  (clock),
      .resetn (resetn),
      .load   (outLoad),
      .clear  (outClear),
      .din    (outDin),
      .valid  (outValid),
      .dout   (outData)
   );

   pipe_de_slot #(.W(BUNDLE_W)) skidSlot (
      .clock  (clock),
      .resetn (resetn),
      .load   (skidLoad),
      .clear  (skidClear),
      .din    (inBundle),
      .valid  (skidValid),
      .dout   (skidData)
   );

   // Write enables are gated so a bubble can never write the register file or memory.
   assign bus.evalid  = outValid;
   assign bus.ewreg   = outValid & outData.wreg;
   assign bus.ewmem   = outValid & outData.wmem;
   assign bus.em2reg  = outData.m2reg;
   assign bus.ealuimm = outData.aluimm;
   assign bus.eshift  = outData.shift;
   assign bus.ejal    = outData.jal;
   assign bus.ealuc   = outData.aluc;
   assign bus.ea      = outData.a;
   assign bus.eb      = outData.b;
   assign bus.eimm    = outData.imm;
   assign bus.epc4    = outData.pc4;
   assign bus.ern0    = outData.rn;

`ifdef PIPE_DE_PERF_EN
   // Counts stalled cycles of the execute side; saturates instead of wrapping.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (bus.flush) begin
         stall_cnt <= '0;
      end else if (outValid && !bus.eready && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_de_skid.sv
// Self-checking bench for pipe_de_skid: directed cases plus random traffic against a queue model.
module tb_pipe_de_skid;
   import pipe_pkg::*;

   typedef logic [BUNDLE_W-1:0] word_t;

   logic    clock;
   logic    resetn;
   bundle_t inB;
   bundle_t q[$];
   logic [31:0] stallModel;
   int      checks;
   int      errors;

   pipe_de_skid_if bus();

`ifdef PIPE_DE_PERF_EN
   logic [31:0] stall_cnt;
`endif

   pipe_de_skid dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
`ifdef PIPE_DE_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   assign bus.dwreg   = inB.wreg;
   assign bus.dm2reg  = inB.m2reg;
   assign bus.dwmem   = inB.wmem;
   assign bus.daluimm = inB.aluimm;
   assign bus.dshift  = inB.shift;
   assign bus.djal    = inB.jal;
   assign bus.daluc   = inB.aluc;
   assign bus.da      = inB.a;
   assign bus.db      = inB.b;
   assign bus.dimm    = inB.imm;
   assign bus.dpc4    = inB.pc4;
   assign bus.drn     = inB.rn;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input word_t obs, input word_t exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t obsBundle();
      return '{wreg: bus.ewreg, m2reg: bus.em2reg, wmem: bus.ewmem,
               aluimm: bus.ealuimm, shift: bus.eshift, jal: bus.ejal,
               aluc: bus.ealuc, a: bus.ea, b: bus.eb, imm: bus.eimm,
               pc4: bus.epc4, rn: bus.ern0};
   endfunction

   function automatic bundle_t randBundle();
      bundle_t b;
      b.wreg   = 1'($urandom);
      b.m2reg  = 1'($urandom);
      b.wmem   = 1'($urandom);
      b.aluimm = 1'($urandom);
      b.shift  = 1'($urandom);
      b.jal    = 1'($urandom);
      b.aluc   = 4'($urandom);
      b.a      = $urandom;
      b.b      = $urandom;
      b.imm    = $urandom;
      b.pc4    = $urandom;
      b.rn     = 5'($urandom);
      return b;
   endfunction

   // Reference: the block is a FIFO of depth two that accepts whenever fewer than two are held.
   task automatic modelUpdate();
      bit doFire, doAccept;
      doFire   = (q.size() > 0) && bus.eready;
      doAccept = bus.dvalid && (q.size() < 2);
      if (bus.flush) stallModel = 0;
      else if (q.size() > 0 && !bus.eready && stallModel != 32'hFFFF_FFFF) stallModel++;
      if (bus.flush) begin
         q.delete();
      end else begin
         if (doFire) void'(q.pop_front());
         if (doAccept) q.push_back(inB);
      end
   endtask

   task automatic compareAll(input string tag);
      checkOutput({tag, ".evalid"}, word_t'(bus.evalid), word_t'(q.size() > 0));
      checkOutput({tag, ".dready"}, word_t'(bus.dready), word_t'(q.size() < 2));
      if (q.size() > 0)
         checkOutput({tag, ".bundle"}, word_t'(obsBundle()), word_t'(q[0]));
      else
         checkOutput({tag, ".wgate"}, word_t'({bus.ewreg, bus.ewmem}), word_t'(2'b00));
`ifdef PIPE_DE_PERF_EN
      checkOutput({tag, ".stall"}, word_t'(stall_cnt), word_t'(stallModel));
`endif
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".evalid"}, word_t'(bus.evalid), word_t'(1'b0));
      checkOutput({tag, ".dready"}, word_t'(bus.dready), word_t'(1'b1));
      checkOutput({tag, ".eall"}, word_t'(obsBundle()), word_t'(0));
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      modelUpdate();
      @(negedge clock);
      compareAll(tag);
   endtask

   task automatic applyStimulus();
      bus.dvalid = ($urandom_range(0, 9) < 7);
      bus.eready = ($urandom_range(0, 9) < 6);
      bus.flush  = ($urandom_range(0, 19) == 0);
      inB        = randBundle();
   endtask

   task automatic drain();
      bus.dvalid = 1'b0;
      bus.eready = 1'b1;
      bus.flush  = 1'b0;
      repeat (3) tick("drain");
   endtask

   initial begin
      int nextOut;
      checks     = 0;
      errors     = 0;
      stallModel = 0;
      resetn     = 1'b0;
      bus.dvalid = 1'b0;
      bus.eready = 1'b0;
      bus.flush  = 1'b0;
      inB        = '0;
      #3;
      checkResetState("reset");
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      compareAll("post_reset");

      // Single bundle into an empty block appears one cycle later.
      inB        = randBundle();
      inB.a      = 32'h1234_5678;
      inB.rn     = 5'd5;
      bus.dvalid = 1'b1;
      bus.eready = 1'b1;
      tick("t030");
      checkOutput("t030.ea", word_t'(bus.ea), word_t'(32'h1234_5678));
      checkOutput("t030.ern0", word_t'(bus.ern0), word_t'(5'd5));
      drain();

      // Fill both slots under backpressure, then release in order.
      bus.eready = 1'b0;
      bus.dvalid = 1'b1;
      inB = randBundle(); inB.pc4 = 32'h4;
      tick("t031.a");
      inB = randBundle(); inB.pc4 = 32'h8;
      tick("t031.b");
      bus.dvalid = 1'b0;
      checkOutput("t031.dready_low", word_t'(bus.dready), word_t'(1'b0));
      checkOutput("t031.hold4", word_t'(bus.epc4), word_t'(32'h4));
      tick("t031.c");
      checkOutput("t031.still4", word_t'(bus.epc4), word_t'(32'h4));
      bus.eready = 1'b1;
      tick("t031.d");
      checkOutput("t031.then8", word_t'(bus.epc4), word_t'(32'h8));
      checkOutput("t031.dready_back", word_t'(bus.dready), word_t'(1'b1));
      tick("t031.e");
      drain();

      // Full throughput: ten bundles back to back.
      nextOut = 0;
      for (int i = 0; i <= 10; i++) begin
         checkOutput("t032.evalid", word_t'(bus.evalid), word_t'(i > 0));
         checkOutput("t032.dready", word_t'(bus.dready), word_t'(1'b1));
         if (bus.evalid) begin
            checkOutput("t032.order", word_t'(bus.epc4), word_t'(32'(nextOut * 4)));
            nextOut++;
         end
         bus.dvalid = (i < 10);
         inB        = randBundle();
         inB.pc4    = 32'(i * 4);
         bus.eready = 1'b1;
         tick("t032");
      end
      checkOutput("t032.count", word_t'(nextOut), word_t'(10));
      drain();

      // Flush with both slots full, then flush together with an accepted bundle.
      bus.eready = 1'b0;
      bus.dvalid = 1'b1;
      inB = randBundle(); inB.wreg = 1'b1; inB.wmem = 1'b1; inB.pc4 = 32'h100;
      tick("t033.a");
      inB = randBundle(); inB.wreg = 1'b1; inB.wmem = 1'b1; inB.pc4 = 32'h104;
      tick("t033.b");
      bus.flush = 1'b1;
      inB = randBundle(); inB.wreg = 1'b1; inB.wmem = 1'b1; inB.pc4 = 32'hDEAD;
      tick("t033.c");
      checkOutput("t033.evalid", word_t'(bus.evalid), word_t'(1'b0));
      checkOutput("t033.ew", word_t'({bus.ewreg, bus.ewmem}), word_t'(2'b00));
      checkOutput("t033.dready", word_t'(bus.dready), word_t'(1'b1));
      tick("t033.d");
      bus.flush  = 1'b0;
      bus.dvalid = 1'b0;
      bus.eready = 1'b1;
      tick("t033.e");
      tick("t033.f");
      checkOutput("t033.gone", word_t'(bus.evalid), word_t'(1'b0));

      // Asynchronous reset mid-stream clears outputs without a clock edge.
      bus.eready = 1'b0;
      bus.dvalid = 1'b1;
      inB = randBundle(); inB.wreg = 1'b1; inB.wmem = 1'b1; inB.a = 32'hFFFF_FFFF;
      tick("t034.a");
      inB = randBundle();
      tick("t034.b");
      bus.dvalid = 1'b0;
      #2 resetn = 1'b0;
      #1 checkResetState("t034.async");
      q.delete();
      stallModel = 0;
      #1 resetn = 1'b1;
      inB        = randBundle();
      bus.dvalid = 1'b1;
      bus.eready = 1'b1;
      tick("t034.relatch");
      checkOutput("t034.latency", word_t'(bus.evalid), word_t'(1'b1));
      drain();

`ifdef PIPE_DE_PERF_EN
      // Stall counter: seven stalled cycles, then flush clears it.
      bus.eready = 1'b0;
      bus.dvalid = 1'b1;
      inB = randBundle();
      tick("t035.load");
      bus.dvalid = 1'b0;
      repeat (7) tick("t035.stall");
      checkOutput("t035.seven", word_t'(stall_cnt), word_t'(32'd7));
      bus.flush = 1'b1;
      tick("t035.flush");
      checkOutput("t035.cleared", word_t'(stall_cnt), word_t'(32'd0));
      drain();
`endif

      // Random traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         applyStimulus();
         tick("rand");
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
